// File: rtl/ped_pkg.sv
// ped_pkg: shared state encoding, lamp bit positions and phase-duration lookup
// for the pedestrian crossing controller.
package ped_pkg;

    typedef enum logic [2:0] {GREEN, YELLOW, ALLRED, WALK, CLEAR} state_t;

    localparam int unsigned L_GREEN  = 0;
    localparam int unsigned L_YELLOW = 1;
    localparam int unsigned L_RED    = 2;
    localparam int unsigned L_PGREEN = 3;
    localparam int unsigned L_PRED   = 4;
    localparam int unsigned LAMP_W   = 5;

    function automatic int unsigned state_dur(
        input state_t      s,
        input int unsigned t_green,
        input int unsigned t_yellow,
        input int unsigned t_allred,
        input int unsigned t_walk,
        input int unsigned t_clear
    );
        return s == GREEN  ? t_green  :
               s == YELLOW ? t_yellow :
               s == ALLRED ? t_allred :
               s == WALK   ? t_walk   : t_clear;
    endfunction

endpackage

// File: rtl/ped_button_debounce.sv
// ped_button_debounce: 2-FF synchroniser, stability counter and one-cycle
// press pulse on each rising edge of the accepted button level.
module ped_button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 160000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_o
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d, dly_q, press_q;
    logic             diff;

    always_comb begin
        diff     = sync_q[1] != stable_q;
        cnt_d    = (diff && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
        stable_d = (diff && cnt_q == LAST) ? sync_q[1] : stable_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            dly_q    <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            dly_q    <= stable_q;
            press_q  <= stable_q & ~dly_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/pedestrian_request_ctrl.sv
// pedestrian_request_ctrl: push-button crossing controller with registered lamps.
// Define PED_BLINK_EN to blink ped_green during a transition-entered CLEAR.
module pedestrian_request_ctrl
    import ped_pkg::*;
#(
    parameter int unsigned TIMER_SCALE     = 16000000,
    parameter int unsigned T_GREEN_MIN     = 10,
    parameter int unsigned T_YELLOW        = 5,
    parameter int unsigned T_ALLRED        = 2,
    parameter int unsigned T_WALK          = 10,
    parameter int unsigned T_CLEAR         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 160000,
    parameter int unsigned SEC_W           = 8
) (
    input  logic pin3_clk_16mhz,
    input  logic rst,
    input  logic pin9_ped_button,
    output logic pin4_green,
    output logic pin5_yellow,
    output logic pin6_red,
    output logic pin7_ped_green,
    output logic pin8_ped_red,
    output logic pin10_wait
);
    localparam int unsigned PRE_W = TIMER_SCALE > 1 ? $clog2(TIMER_SCALE) : 1;
    localparam int unsigned T_MAX = 1 << SEC_W;

    if (T_GREEN_MIN < 1 || T_GREEN_MIN >= T_MAX || T_YELLOW < 1 || T_YELLOW >= T_MAX ||
        T_ALLRED < 1 || T_ALLRED >= T_MAX || T_WALK < 1 || T_WALK >= T_MAX ||
        T_CLEAR < 1 || T_CLEAR >= T_MAX) begin : g_bad_duration
        $error("pedestrian_request_ctrl: every T_* must lie in [1, 2**SEC_W)");
    end

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [LAMP_W-1:0] lamp_q, lamp_d;
    logic              req_q, req_d, req, press, tick, expired, entry;
`ifdef PED_BLINK_EN
    logic              blink_q, blink_d;
`endif

    ped_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button (
        .clk     (pin3_clk_16mhz),
        .rst     (rst),
        .raw_i   (pin9_ped_button),
        .press_o (press)
    );

    // Expiry looks one tick ahead so each phase spans exactly T*TIMER_SCALE cycles.
    always_comb begin
        tick    = pre_q == PRE_W'(TIMER_SCALE - 1);
        expired = sec_q == '0 || (sec_q == SEC_W'(1) && tick);
        req     = req_q | (press & (state_q != WALK));
        state_d = !expired          ? state_q :
                  state_q == GREEN  ? (req ? YELLOW : GREEN) :
                  state_q == YELLOW ? ALLRED :
                  state_q == ALLRED ? WALK :
                  state_q == WALK   ? CLEAR : GREEN;
        entry   = state_d != state_q;
        pre_d   = (entry || tick) ? '0 : pre_q + 1'b1;
        sec_d   = entry ? SEC_W'(state_dur(state_d, T_GREEN_MIN, T_YELLOW, T_ALLRED, T_WALK, T_CLEAR)) :
                  (tick && sec_q != '0) ? sec_q - 1'b1 : sec_q;
        req_d   = (entry && state_d == WALK) ? 1'b0 : req;
        lamp_d           = '0;
        lamp_d[L_GREEN]  = state_d == GREEN;
        lamp_d[L_YELLOW] = state_d == YELLOW;
        lamp_d[L_RED]    = state_d != GREEN && state_d != YELLOW;
`ifdef PED_BLINK_EN
        blink_d          = entry ? state_d == CLEAR : blink_q;
        lamp_d[L_PGREEN] = state_d == WALK || (blink_d && pre_d < PRE_W'(TIMER_SCALE / 2));
        lamp_d[L_PRED]   = state_d != WALK && !blink_d;
`else
        lamp_d[L_PGREEN] = state_d == WALK;
        lamp_d[L_PRED]   = state_d != WALK;
`endif
    end

    always_ff @(posedge pin3_clk_16mhz or posedge rst) begin
        if (rst) begin
            state_q        <= CLEAR;
            pre_q          <= '0;
            sec_q          <= SEC_W'(T_CLEAR);
            req_q          <= 1'b0;
            lamp_q         <= '0;
            lamp_q[L_RED]  <= 1'b1;
            lamp_q[L_PRED] <= 1'b1;
`ifdef PED_BLINK_EN
            blink_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sec_q   <= sec_d;
            req_q   <= req_d;
            lamp_q  <= lamp_d;
`ifdef PED_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    assign pin4_green     = lamp_q[L_GREEN];
    assign pin5_yellow    = lamp_q[L_YELLOW];
    assign pin6_red       = lamp_q[L_RED];
    assign pin7_ped_green = lamp_q[L_PGREEN];
    assign pin8_ped_red   = lamp_q[L_PRED];
    assign pin10_wait     = req_q;

endmodule

// File: tb/tb_pedestrian_request_ctrl.sv
// tb_pedestrian_request_ctrl: directed self-checking bench; lamp vector is
// {green, yellow, red, ped_green, ped_red, wait}.
module tb_pedestrian_request_ctrl;

    logic clk = 1'b0;
    logic rst, btn;
    logic green, yellow, red, ped_green, ped_red, wt;
    logic [5:0] lamps;
    int checks = 0;
    int errors = 0;

    pedestrian_request_ctrl #(
        .TIMER_SCALE     (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .pin3_clk_16mhz  (clk),
        .rst             (rst),
        .pin9_ped_button (btn),
        .pin4_green      (green),
        .pin5_yellow     (yellow),
        .pin6_red        (red),
        .pin7_ped_green  (ped_green),
        .pin8_ped_red    (ped_red),
        .pin10_wait      (wt)
    );

    always #5 clk = ~clk;
    assign lamps = {green, yellow, red, ped_green, ped_red, wt};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] exp_clear(input int k, input logic w);
`ifdef PED_BLINK_EN
        return {3'b001, (k % 4) < 2, 1'b0, w};
`else
        return {3'b001, 1'b0, 1'b1, w};
`endif
    endfunction

    // Called on a phase's entry edge: n-1 cycles hold 'during', edge n shows 'nxt'.
    task automatic phase(input string tag, input int n, input logic [5:0] during, input logic [5:0] nxt);
        int bad = 0;
        for (int i = 1; i < n; i++) begin
            step(1);
            if (lamps !== during) bad++;
        end
        check(tag, bad, 0);
        step(1);
        check({tag, "_next"}, lamps, nxt);
    endtask

    task automatic run_clear(input string tag, input logic w);
        int bad = 0;
        for (int k = 1; k < 20; k++) begin
            step(1);
            if (lamps !== exp_clear(k, w)) bad++;
        end
        check(tag, bad, 0);
        step(1);
        check({tag, "_green"}, lamps, {5'b10001, w});
    endtask

    task automatic serve_to_walk(input string tag);
        phase({tag, "_yellow"}, 20, 6'b010011, 6'b001011);
        phase({tag, "_allred"}, 8, 6'b001011, 6'b001100);
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        step(2);
        check("por_lamps", lamps, 6'b001010);
        rst = 1'b0;
        phase("por_clear", 20, 6'b001010, 6'b100010);

        phase("idle", 2000, 6'b100010, 6'b100010);

        btn = 1'b1;
        phase("late_press", 7, 6'b100010, 6'b010011);
        serve_to_walk("late");
        phase("late_walk", 40, 6'b001100, exp_clear(0, 1'b0));
        btn = 1'b0;
        run_clear("late_clear", 1'b0);

        step(4);
        btn = 1'b1;
        phase("min_wait", 7, 6'b100010, 6'b100011);
        phase("min_green", 29, 6'b100011, 6'b010011);
        serve_to_walk("min");
        phase("hold_walk", 40, 6'b001100, exp_clear(0, 1'b0));
        btn = 1'b0;
        run_clear("hold_clear", 1'b0);

        phase("pre_glitch", 50, 6'b100010, 6'b100010);
        btn = 1'b1;
        step(2);
        btn = 1'b0;
        phase("glitch", 20, 6'b100010, 6'b100010);

        btn = 1'b1;
        phase("req3", 7, 6'b100010, 6'b010011);
        btn = 1'b0;
        serve_to_walk("req3");
        step(2);
        btn = 1'b1;
        step(8);
        btn = 1'b0;
        phase("walk_press", 30, 6'b001100, exp_clear(0, 1'b0));
        btn = 1'b1;
        for (int k = 1; k < 20; k++) begin
            step(1);
            if (k == 8) btn = 1'b0;
            check($sformatf("clear_press_%0d", k), lamps, exp_clear(k, k >= 7));
        end
        step(1);
        check("clear_press_green", lamps, 6'b100011);
        phase("served", 40, 6'b100011, 6'b010011);

        serve_to_walk("last");
        step(10);
        #3;
        rst = 1'b1;
        #1;
        check("rst_walk", lamps, 6'b001010);
        step(1);
        rst = 1'b0;
        phase("rst_clear", 20, 6'b001010, 6'b100010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
